// File: rtl/ebpf_fetch_pkg.sv
// Shared types for the eBPF instruction fetch stage: exception codes and the
// {data, err} entry held in the prefetch buffer.
package ebpf_fetch_pkg;

  localparam int INSTR_BYTES = 8;

  typedef enum logic [1:0] {
    NONE         = 2'b00,
    MISALIGNED   = 2'b01,
    BUS_ERR      = 2'b10,
    OUT_OF_RANGE = 2'b11
  } fetch_exc_e;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } fifo_entry_t;

endpackage

// File: rtl/ebpf_fetch_unit_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush, occupancy count and
// simultaneous push/pop. Overflow is prevented upstream by the request cap.
module fetch_fifo
  import ebpf_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fifo_entry_t      pushEntry,
  input  logic             pop,
  output fifo_entry_t      headEntry,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // Flush wins over push/pop so a redirect never keeps a stale word.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign headEntry = mem[rdPtr];

endmodule

// File: rtl/ebpf_fetch_unit.sv
// Fetch stage ahead of the eBPF core: sequential prefetch into a small buffer,
// jump detection by address mismatch, and discard of in-flight stale responses.
module ebpf_fetch_unit
  import ebpf_fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IM_BYTES = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] fetch_addr,
  output logic [63:0] instruction,
  output logic        instr_valid,
  output logic [1:0]  instr_exc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [63:0] IM_LIMIT = 64'(IM_BYTES);

  logic [63:0] streamBase;
  logic [63:0] pfAddr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifoCount;
  logic [SW-1:0] occupancy;
  fifo_entry_t headEntry;
  fifo_entry_t rspEntry;
  fetch_exc_e excCode;
  logic misaligned, outOfRange, illegal, hit, miss, headPresent;
  logic reqFire, dropRsp, pushRsp, popHead;

  assign misaligned  = fetch_addr[2:0] != 3'b000;
  assign outOfRange  = fetch_addr >= IM_LIMIT;
  assign illegal     = misaligned || outOfRange;
  assign hit         = !illegal && (fetch_addr == streamBase);
  assign miss        = !illegal && !hit;
  assign headPresent = fifoCount != '0;
  assign occupancy   = SW'(fifoCount) + SW'(outstanding);

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    instr_valid   = 1'b0;
    instruction   = '0;
    excCode       = NONE;
    mem_req_valid = 1'b0;
    if (reset) begin
      if (misaligned) begin
        excCode = MISALIGNED;
      end else if (outOfRange) begin
        excCode = OUT_OF_RANGE;
      end else if (hit && headPresent) begin
        if (headEntry.err) begin
          excCode = BUS_ERR;
        end else begin
          instr_valid = 1'b1;
          instruction = headEntry.data;
        end
      end
      mem_req_valid = hit && (occupancy < SW'(DEPTH)) && (pfAddr < IM_LIMIT);
    end
  end

  assign instr_exc    = excCode;
  assign mem_req_addr = pfAddr;

  assign reqFire  = mem_req_valid && mem_req_ready;
  assign popHead  = instr_valid;
  assign dropRsp  = mem_rsp_valid && (discard != '0);
  assign pushRsp  = mem_rsp_valid && !dropRsp && !miss;
  assign rspEntry = '{data: mem_rsp_data, err: mem_rsp_err};

  // On a miss every response still owed by memory belongs to the old stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streamBase  <= '0;
      pfAddr      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (miss) begin
      streamBase  <= fetch_addr;
      pfAddr      <= fetch_addr;
      outstanding <= outstanding - CW'(mem_rsp_valid);
      discard     <= outstanding - CW'(mem_rsp_valid);
    end else begin
      if (popHead) begin
        streamBase <= streamBase + 64'(INSTR_BYTES);
      end
      if (reqFire) begin
        pfAddr <= pfAddr + 64'(INSTR_BYTES);
      end
      outstanding <= outstanding + CW'(reqFire) - CW'(mem_rsp_valid);
      if (dropRsp) begin
        discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CW)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (miss),
    .push     (pushRsp),
    .pushEntry(rspEntry),
    .pop      (popHead),
    .headEntry(headEntry),
    .count    (fifoCount)
  );

endmodule

// File: tb/tb_ebpf_fetch_unit.sv
// Bench for ebpf_fetch_unit: queue-based reference model, latency-modelled
// instruction memory, directed scenarios and a randomized phase.
module tb_ebpf_fetch_unit;

  localparam int DEPTH    = 4;
  localparam int IM_BYTES = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic [63:0] instruction;
  logic        instr_valid;
  logic [1:0]  instr_exc;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;

  always #5 clk = ~clk;

  ebpf_fetch_unit #(.DEPTH(DEPTH), .IM_BYTES(IM_BYTES)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_addr   (fetch_addr),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_exc    (instr_exc),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err)
  );

  typedef struct {logic [63:0] addr; int due;} pend_t;
  typedef struct {logic [63:0] data; logic err;} ent_t;

  pend_t       pend[$];
  ent_t        mBuf[$];
  bit          mInflight[$];
  logic [63:0] mBase = '0;
  logic [63:0] mPf = '0;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          memLat = 2;
  int          lastDue = 0;
  bit          randLat = 0;
  logic [63:0] errAddr = '1;
  logic [63:0] curFetch = '0;
  bit          readyCtl = 1;

  bit          eValid, eReq, eMiss;
  logic [63:0] eInstr;
  logic [1:0]  eExc;

  function automatic logic [63:0] memWord(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0] ^ 32'h1234_5678};
  endfunction

  function void check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endfunction

  task applyStimulus();
    if (!reset) begin
      pend.delete();
      lastDue = cycle;
    end
    fetch_addr    = curFetch;
    mem_req_ready = readyCtl;
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memWord(pend[0].addr);
      mem_rsp_err   = (pend[0].addr == errAddr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      mem_rsp_err   = 1'($urandom);
    end
  endtask

  // Expected outputs derived from the model's buffer and in-flight queues.
  function void computeModel();
    bit misal, oor, hit, head;
    misal  = curFetch[2:0] != 3'b000;
    oor    = curFetch >= 64'(IM_BYTES);
    eValid = 0; eInstr = '0; eExc = 2'b00; eReq = 0; eMiss = 0;
    if (reset) begin
      hit   = !misal && !oor && (curFetch == mBase);
      eMiss = !misal && !oor && !hit;
      head  = mBuf.size() > 0;
      if (misal) eExc = 2'b01;
      else if (oor) eExc = 2'b11;
      else if (hit && head && mBuf[0].err) eExc = 2'b10;
      eValid = hit && head && !mBuf[0].err;
      if (eValid) eInstr = mBuf[0].data;
      eReq = hit && (mBuf.size() + mInflight.size() < DEPTH) && (mPf < 64'(IM_BYTES));
    end
  endfunction

  task checkOutput();
    computeModel();
    check64("instr_valid", instr_valid, eValid);
    check64("instruction", instruction, eInstr);
    check64("instr_exc", instr_exc, eExc);
    check64("mem_req_valid", mem_req_valid, eReq);
    if (eReq) check64("mem_req_addr", mem_req_addr, mPf);
    check64("outstanding_cap", 64'(pend.size() <= DEPTH), 64'd1);
  endtask

  task updateAll();
    int due;
    bit stale;
    if (!reset) begin
      mBuf.delete(); mInflight.delete(); mBase = '0; mPf = '0;
      return;
    end
    if (mem_rsp_valid) void'(pend.pop_front());
    if (mem_req_valid && mem_req_ready) begin
      due = cycle + (randLat ? int'($urandom_range(1, 4)) : memLat);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      pend.push_back('{addr: mem_req_addr, due: due});
    end
    if (eValid) begin
      void'(mBuf.pop_front());
      mBase += 64'd8;
    end
    if (mem_rsp_valid && mInflight.size() > 0) begin
      stale = mInflight.pop_front();
      if (!stale && !eMiss) mBuf.push_back('{data: mem_rsp_data, err: mem_rsp_err});
    end
    if (eReq && mem_req_ready) begin
      mInflight.push_back(1'b0);
      mPf += 64'd8;
    end
    if (eMiss) begin
      mBuf.delete();
      foreach (mInflight[i]) mInflight[i] = 1'b1;
      mBase = curFetch;
      mPf   = curFetch;
    end
  endtask

  task stepPre();
    applyStimulus();
    #3;
  endtask

  task stepPost();
    bit adv;
    adv = eValid;
    updateAll();
    @(posedge clk);
    #1;
    cycle++;
    if (adv) curFetch += 64'd8;
  endtask

  task stepCycle();
    stepPre();
    checkOutput();
    stepPost();
  endtask

  task checkIdle(input string name);
    check64({name, "_valid"}, instr_valid, 0);
    check64({name, "_instr"}, instruction, 0);
    check64({name, "_exc"}, instr_exc, 0);
    check64({name, "_req"}, mem_req_valid, 0);
  endtask

  initial begin
    int tRed, pendAtJump, rspCount, r;
    bit found;
    @(posedge clk);
    #1;

    // Reset, then redirect to 0x40 with latency 2.
    reset = 1'b0; curFetch = 64'h40;
    for (int k = 0; k < 2; k++) begin
      stepPre(); checkOutput(); checkIdle("reset_state"); stepPost();
    end
    reset = 1'b1;
    tRed = cycle;
    for (int k = 0; k < 8; k++) begin
      stepPre(); checkOutput();
      if (k == 1) begin
        check64("first_req_valid", mem_req_valid, 1);
        check64("first_req_addr", mem_req_addr, 64'h40);
      end
      if (k == 3) check64("no_valid_before_fill", instr_valid, 0);
      if (k >= 4 && k <= 6) begin
        check64("stream_valid", instr_valid, 1);
        check64("stream_data", instruction, memWord(64'h40 + 64'(8 * (k - 4))));
      end
      stepPost();
    end

    // Jump to 0x100 with requests in flight: stale responses are dropped.
    curFetch = 64'h100;
    stepPre(); pendAtJump = pend.size(); rspCount = 0; checkOutput();
    if (mem_rsp_valid) rspCount++;
    stepPost();
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      stepPre(); checkOutput();
      if (instr_valid) begin
        found = 1;
        check64("jump_first_data", instruction, memWord(64'h100));
        check64("jump_rsp_count", rspCount, pendAtJump + 1);
      end else if (mem_rsp_valid) rspCount++;
      stepPost();
    end
    check64("jump_found", found, 1);

    // Bus error on 0x58 is held until redirect.
    errAddr = 64'h58; curFetch = 64'h40; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      stepPre(); checkOutput();
      found = (instr_exc == 2'b10);
      stepPost();
    end
    check64("bus_err_seen", found, 1);
    for (int k = 0; k < 5; k++) begin
      stepPre(); checkOutput();
      check64("bus_err_hold_valid", instr_valid, 0);
      check64("bus_err_hold_exc", instr_exc, 2'b10);
      check64("bus_err_hold_addr", fetch_addr, 64'h58);
      stepPost();
    end
    curFetch = 64'h0; errAddr = '1;
    stepPre(); checkOutput(); check64("bus_err_cleared", instr_exc, 2'b00); stepPost();
    for (int k = 0; k < 6; k++) stepCycle();

    // Misaligned and out-of-range addresses.
    curFetch = 64'h44;
    stepPre(); checkOutput();
    check64("misaligned_exc", instr_exc, 2'b01);
    check64("misaligned_noreq", mem_req_valid, 0);
    stepPost();
    curFetch = 64'(IM_BYTES);
    stepPre(); checkOutput();
    check64("oor_exc", instr_exc, 2'b11);
    check64("oor_noreq", mem_req_valid, 0);
    stepPost();
    curFetch = 64'(IM_BYTES) - 64'd24;
    for (int k = 0; k < 15; k++) stepCycle();
    stepPre(); checkOutput(); check64("ran_off_end_exc", instr_exc, 2'b11); stepPost();

    // Backpressure for 10 cycles mid-stream.
    curFetch = 64'h200;
    for (int k = 0; k < 6; k++) stepCycle();
    readyCtl = 0;
    for (int k = 0; k < 10; k++) stepCycle();
    readyCtl = 1;
    for (int k = 0; k < 12; k++) stepCycle();

    // Reset with requests in flight.
    curFetch = 64'h300; memLat = 3;
    for (int k = 0; k < 20 && pend.size() < 2; k++) stepCycle();
    check64("inflight_before_reset", 64'(pend.size() >= 2), 64'd1);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stepPre(); checkOutput(); checkIdle("mid_reset"); stepPost();
    end
    reset = 1'b1; curFetch = 64'h0;
    stepPre(); checkOutput();
    check64("post_reset_req", mem_req_valid, 1);
    check64("post_reset_addr", mem_req_addr, 64'h0);
    check64("post_reset_rsp", mem_rsp_valid, 0);
    stepPost();

    // Randomized traffic.
    randLat = 1;
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 999);
      reset = (r < 3) ? 1'b0 : 1'b1;
      readyCtl = ($urandom_range(0, 3) != 0);
      if (r >= 3 && r < 60) curFetch = 64'($urandom_range(0, 127)) << 3;
      else if (r >= 60 && r < 70) curFetch = 64'(IM_BYTES) - (64'($urandom_range(0, 8)) << 3);
      else if (r >= 70 && r < 78) curFetch = (64'($urandom_range(0, 127)) << 3) | 64'($urandom_range(1, 7));
      if (r >= 990) errAddr = 64'($urandom_range(0, 127)) << 3;
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
